// File: rtl/fifo_rd_drainer.sv
// rtl/fifo_rd_drainer.sv - async FIFO read-side drainer feeding a 2-entry valid/ready output buffer
// Issues FIFO reads only when the word landing next cycle is guaranteed a buffer slot.
module fifo_rd_drainer #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 9
) (
  input  logic                r_clk,
  input  logic                r_rst,
  input  logic                en,
  input  logic                rempty,
  output logic                r_inc,
  input  logic [DATASIZE-1:0] rdata,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATASIZE-1:0] m_data,
  output logic                busy,
  output logic [ADDRSIZE:0]   word_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t              state;
  state_t              state_nxt;
  logic                inflight;
  logic [1:0]          occ;
  logic [DATASIZE-1:0] buf_head;
  logic [DATASIZE-1:0] buf_tail;
  logic                pop;
  logic                push;
  logic [2:0]          fill_after;

  assign m_valid = (occ != 2'd0);
  assign m_data  = buf_head;
  assign busy    = (state != IDLE);
  assign pop     = m_valid && m_ready;
  assign push    = inflight;

  // Slots committed at the end of this cycle; a new read is allowed only if one stays free.
  always_comb begin
    fill_after = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    r_inc      = (state == RUN) && !rempty && (fill_after < 3'd2);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = STOP;
      STOP: begin
        if (en)
          state_nxt = RUN;
        else if (!inflight && occ == 2'd0)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state    <= IDLE;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= r_inc;
    end
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      occ      <= 2'd0;
      buf_head <= '0;
      buf_tail <= '0;
    end else begin
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
      if (pop) begin
        if (push) begin
          if (occ == 2'd1) begin
            buf_head <= rdata;
          end else begin
            buf_head <= buf_tail;
            buf_tail <= rdata;
          end
        end else if (occ == 2'd2) begin
          buf_head <= buf_tail;
        end
      end else if (push) begin
        if (occ == 2'd0)
          buf_head <= rdata;
        else
          buf_tail <= rdata;
      end
    end
  end

  always_ff @(posedge r_clk) begin
    if (r_rst)
      word_cnt <= '0;
    else if (pop)
      word_cnt <= word_cnt + {{ADDRSIZE{1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_fifo_rd_drainer.sv
// tb/tb_fifo_rd_drainer.sv - scoreboard bench for fifo_rd_drainer
module tb_fifo_rd_drainer;

  logic       r_clk = 1'b0;
  logic       r_rst = 1'b1;
  logic       en = 1'b0;
  logic       rempty = 1'b1;
  logic       m_ready = 1'b0;
  logic [7:0] rdata = 8'h00;
  logic       r_inc;
  logic       m_valid;
  logic       busy;
  logic [7:0] m_data;
  logic [9:0] word_cnt;

  fifo_rd_drainer #(.DATASIZE(8), .ADDRSIZE(9)) dut (
    .r_clk(r_clk), .r_rst(r_rst), .en(en), .rempty(rempty), .r_inc(r_inc),
    .rdata(rdata), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .word_cnt(word_cnt)
  );

  always #5 r_clk = ~r_clk;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         deliv = 0;
  int         issued = 0;
  int         first_cyc = -1;
  int         last_cyc = -1;
  bit         pend = 1'b0;
  bit         mon_off = 1'b1;
  bit         stalled = 1'b0;
  logic [7:0] stall_data = 8'h00;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // FIFO read-port model: a word requested in cycle t appears on rdata for cycle t+1.
  always @(posedge r_clk) begin
    cyc++;
    #1;
    if (pend) begin
      if (fifo_q.size() > 0) rdata = fifo_q.pop_front();
      pend = 1'b0;
    end
    rempty = (fifo_q.size() == 0);
  end

  always @(negedge r_clk) begin
    if (r_inc) begin
      pend = 1'b1;
      issued++;
    end
    if (!mon_off) begin
      if (r_inc && rempty) begin
        vectors++; miscompares++;
        $display("FAIL rd_on_empty: r_inc=1 with rempty=1 at cycle %0d", cyc);
      end
      if (stalled) begin
        vectors++;
        if (!m_valid || m_data !== stall_data) begin
          miscompares++;
          $display("FAIL stall_hold: got valid=%0b data=%02h expected valid=1 data=%02h",
                   m_valid, m_data, stall_data);
        end
      end
      if (m_valid && m_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_word: got %02h with empty scoreboard", m_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (m_data !== e) begin
            miscompares++;
            $display("FAIL data: got %02h expected %02h", m_data, e);
          end
        end
        deliv++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      if (issued - deliv > 2) begin
        vectors++; miscompares++;
        $display("FAIL overflow: outstanding %0d expected <= 2", issued - deliv);
      end
      stalled    = m_valid && !m_ready;
      stall_data = m_data;
    end
  end

  task automatic preload(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      logic [7:0] w;
      w = base + 8'(i);
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
  endtask

  task automatic wait_deliv(input int n, input int budget, input string name);
    int k = 0;
    while (deliv < n && k < budget) begin
      @(negedge r_clk);
      k++;
    end
    chk(name, deliv, n);
  endtask

  task automatic stop_and_idle(input string name);
    int k = 0;
    @(posedge r_clk); #2;
    en = 1'b0;
    @(negedge r_clk);
    while (busy && k < 40) begin
      @(negedge r_clk);
      k++;
    end
    chk(name, int'(busy), 0);
  endtask

  initial begin
    logic [3:0] pat;
    int k;
    pat = 4'b1001;

    // Reset with arbitrary inputs
    en = 1'b1; m_ready = 1'b1;
    repeat (2) @(posedge r_clk);
    @(negedge r_clk);
    chk("rst_r_inc", int'(r_inc), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_word_cnt", int'(word_cnt), 0);
    @(posedge r_clk); #2;
    r_rst = 1'b0; en = 1'b0;
    issued = 0; pend = 1'b0; mon_off = 1'b0;

    // Streaming at full rate
    @(posedge r_clk); #2;
    preload(16, 8'h01);
    first_cyc = -1;
    en = 1'b1; m_ready = 1'b1;
    wait_deliv(16, 80, "stream_count");
    chk("stream_rate", last_cyc - first_cyc, 15);
    stop_and_idle("stream_idle");
    chk("stream_word_cnt", int'(word_cnt), 16);

    // Backpressure with m_ready pattern 1,0,0,1
    @(posedge r_clk); #2;
    preload(8, 8'hA0);
    en = 1'b1;
    k = 0;
    while (deliv < 24 && k < 200) begin
      m_ready = pat[k % 4];
      k++;
      @(posedge r_clk); #2;
    end
    chk("bp_count", deliv, 24);
    m_ready = 1'b1;
    stop_and_idle("bp_idle");
    chk("bp_word_cnt", int'(word_cnt), 24);

    // Stop right after the first read
    @(posedge r_clk); #2;
    preload(10, 8'h50);
    en = 1'b1; m_ready = 1'b1;
    k = 0;
    @(negedge r_clk);
    while (!r_inc && k < 20) begin
      @(negedge r_clk);
      k++;
    end
    en = 1'b0;
    chk("stop_saw_read", k < 20 ? 1 : 0, 1);
    k = 0;
    repeat (2) @(negedge r_clk);
    while (busy && k < 20) begin
      @(negedge r_clk);
      k++;
    end
    chk("stop_busy", int'(busy), 0);
    chk("stop_delivered", deliv, 25);
    chk("stop_fifo_left", fifo_q.size(), 9);
    chk("stop_word_cnt", int'(word_cnt), 25);
    @(posedge r_clk); #2;
    en = 1'b1;
    wait_deliv(34, 60, "resume_count");
    stop_and_idle("resume_idle");
    chk("resume_word_cnt", int'(word_cnt), 34);

    // Reset with a full output buffer
    @(posedge r_clk); #2;
    preload(4, 8'hC0);
    m_ready = 1'b0; en = 1'b1;
    repeat (8) @(posedge r_clk);
    @(negedge r_clk);
    chk("full_m_valid", int'(m_valid), 1);
    chk("full_r_inc", int'(r_inc), 0);
    chk("full_outstanding", issued - deliv, 2);
    @(posedge r_clk); #2;
    mon_off = 1'b1; r_rst = 1'b1;
    @(posedge r_clk); #2;
    r_rst = 1'b0; en = 1'b0;
    @(negedge r_clk);
    chk("midrst_m_valid", int'(m_valid), 0);
    chk("midrst_word_cnt", int'(word_cnt), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_r_inc", int'(r_inc), 0);
    fifo_q.delete(); exp_q.delete();
    deliv = 0; issued = 0; pend = 1'b0; stalled = 1'b0;
    mon_off = 1'b0;

    // Counter wrap at 2^10
    @(posedge r_clk); #2;
    preload(1025, 8'h00);
    en = 1'b1; m_ready = 1'b1;
    wait_deliv(1025, 1300, "wrap_count");
    stop_and_idle("wrap_idle");
    chk("wrap_word_cnt", int'(word_cnt), 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
